// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the floating-point divider front end.
package fp_div_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  // IEEE-754 single precision fields, MSB first.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } fp32_t;

  // Arbiter operation phases: pick a requester, wait out the divider, hand back the result.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fp_div_arb_state_e;

  // True for +0 and -0; denormals are not zero.
  function automatic logic is_zero(input fp32_t v);
    return (v.exp == '0) && (v.mant == '0);
  endfunction

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping past N-1.
module fp_rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk the ring starting just after ptr; the first asserted request wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    cand         = ptr;
    for (int k = 0; k < N; k++) begin
      if (cand == IDX_W'(N - 1)) begin
        cand = '0;
      end else begin
        cand = cand + IDX_W'(1);
      end
      if (!any && req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    if (any) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one fixed-latency floating-point divider between N_REQ requesters.
module fp_div_arbiter
  import fp_div_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DIV_LATENCY = 2,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*FP_W-1:0] req_a,
  input  logic [N_REQ*FP_W-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [FP_W-1:0]       rsp_result,
  output logic                  rsp_dbz,
  output logic [FP_W-1:0]       div_a,
  output logic [FP_W-1:0]       div_b,
  input  logic [FP_W-1:0]       div_result,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  fp_div_arb_state_e state;
  fp_div_arb_state_e state_next;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  owner_id;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;

  logic [FP_W-1:0]  sel_a;
  logic [FP_W-1:0]  sel_b;

  logic             accept;
  logic             capture;

  fp_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req          (req_valid),
    .ptr          (ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  // Grants are only offered while idle, and never while reset is held low.
  assign req_ready = (state == IDLE && reset) ? grant_onehot : '0;

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // A grant in IDLE is an accept: the requester's valid is already part of the grant.
  assign accept  = (state == IDLE) && grant_any;
  assign capture = (state == WAIT) && (cnt == '0);

  // Steer the granted requester's operands toward the operand registers.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  // Next-state logic for the single outstanding divider operation.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset drops any operation in flight without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands, owner and round-robin pointer change only on an accept edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_a    <= '0;
      div_b    <= '0;
      owner_id <= '0;
      ptr      <= ID_W'(N_REQ - 1);
    end else if (accept) begin
      div_a    <= sel_a;
      div_b    <= sel_b;
      owner_id <= grant_idx;
      ptr      <= grant_idx;
    end
  end

  // Counts down the divider latency; zero in WAIT marks the capture edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(DIV_LATENCY);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Response registers load once per operation and hold through back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_dbz    <= 1'b0;
    end else if (capture) begin
      rsp_id     <= owner_id;
      rsp_result <= div_result;
      rsp_dbz    <= is_zero(fp32_t'(div_b));
    end
  end

endmodule
